io_peripherie: RTL

Memory-mapped I/O responder on the CPU data bus, the slave end of the LeseDaten/SchreibeDaten ↔ DatenGeladen/DatenGespeichert handshake. It is selected when DatenAdresse[31]==1 and replaces the constant-1 acknowledge path with a real multi-cycle responder. It holds the LED register, a free-running cycle counter and an 8N1 UART transmitter whose data-register writes stall the CPU while the line is busy.

---
 rtl/io_pkg.sv | 23 ++
 rtl/io_peripherie_if.sv | 28 ++
 rtl/uart_sender.sv | 60 ++++++
 rtl/io_peripherie.sv | 118 +++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped I/O responder.
//   ADDR_BITS         word-address width inside the I/O window
//   UART_FRAME_BITS   start + 8 data + stop
//   REG_*             register word offsets
//   io_state_e        bus-handshake FSM states
package io_pkg;

  localparam int ADDR_BITS       = 3;
  localparam int UART_FRAME_BITS = 10;

  localparam logic [ADDR_BITS-1:0] REG_LED         = ADDR_BITS'(0);
  localparam logic [ADDR_BITS-1:0] REG_ZAEHLER     = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0] REG_UART_DATEN  = ADDR_BITS'(2);
  localparam logic [ADDR_BITS-1:0] REG_UART_STATUS = ADDR_BITS'(3);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STALL   = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } io_state_e;

endpackage

// File: rtl/io_peripherie_if.sv
// CPU data-bus handshake between the CPU (master) and the I/O responder (slave).
//   LesenAn / SchreibenAn     level requests, held until acknowledged
//   Adresse, DatenRein        word address and write data
//   DatenRaus                 read data, valid with DatenBereit
//   DatenBereit               read acknowledge pulse
//   DatenGeschrieben          write acknowledge pulse
interface io_peripherie_if;
  import io_pkg::*;

  logic                 LesenAn;
  logic                 SchreibenAn;
  logic [ADDR_BITS-1:0] Adresse;
  logic [31:0]          DatenRein;
  logic [31:0]          DatenRaus;
  logic                 DatenBereit;
  logic                 DatenGeschrieben;

  modport master (
    output LesenAn, SchreibenAn, Adresse, DatenRein,
    input  DatenRaus, DatenBereit, DatenGeschrieben
  );

  modport slave (
    input  LesenAn, SchreibenAn, Adresse, DatenRein,
    output DatenRaus, DatenBereit, DatenGeschrieben
  );

endinterface

// File: rtl/uart_sender.sv
// 8N1 serial transmitter.
//   Clock, Reset   system clock, async active-high reset
//   Start, Byte    load a frame; honoured only while not Busy
//   Busy           frame in progress; drops during the last stop-bit cycle so a
//                  new frame can be loaded on the edge that ends the stop bit
//   Tx             serial line, idle high
module uart_sender
  import io_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 217
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic [7:0] Byte,
  output logic       Busy,
  output logic       Tx
);

  logic        busy_q;
  logic        tx_q;
  logic [15:0] takt_q;
  logic [3:0]  bit_q;
  logic [8:0]  schiebe_q;
  logic        frei;

  // Free when idle or on the final cycle of the stop bit.
  assign frei = !busy_q || (takt_q == '0 && bit_q == '0);
  assign Busy = !frei;
  assign Tx   = tx_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      busy_q    <= 1'b0;
      tx_q      <= 1'b1;
      takt_q    <= '0;
      bit_q     <= '0;
      schiebe_q <= '1;
    end else if (Start && frei) begin
      busy_q    <= 1'b1;
      tx_q      <= 1'b0;
      takt_q    <= 16'(CLOCKS_PER_BIT - 1);
      bit_q     <= 4'(UART_FRAME_BITS - 1);
      schiebe_q <= {1'b1, Byte};
    end else if (busy_q) begin
      if (takt_q != '0) begin
        takt_q <= takt_q - 16'd1;
      end else if (bit_q == '0) begin
        busy_q <= 1'b0;
        tx_q   <= 1'b1;
      end else begin
        tx_q      <= schiebe_q[0];
        schiebe_q <= {1'b1, schiebe_q[8:1]};
        bit_q     <= bit_q - 4'd1;
        takt_q    <= 16'(CLOCKS_PER_BIT - 1);
      end
    end
  end

endmodule

// File: rtl/io_peripherie.sv
// Memory-mapped I/O responder: LED register, free-running cycle counter and
// UART transmitter behind a request/acknowledge bus handshake.
//   Clock, Reset   system clock, async active-high reset
//   bus            slave side of the CPU data-bus handshake
//   Led            LED register
//   UartTx         serial output, idle high
//
// state   | meaning
// IDLE    | waiting for a request; executes it on the sampling edge
// STALL   | UART data write waiting for the transmitter to free up
// ACK     | one-cycle acknowledge pulse
// RELEASE | waiting for both requests to drop
module io_peripherie
  import io_pkg::*;
#(
  parameter int          CLOCKS_PER_BIT = 217,
  parameter logic [31:0] ZAEHLER_START  = 32'd0  // counter value after reset; 0 in normal use
) (
  input  logic           Clock,
  input  logic           Reset,
  io_peripherie_if.slave bus,
  output logic [7:0]     Led,
  output logic           UartTx
);

  io_state_e   state_q;
  logic [7:0]  led_q;
  logic [7:0]  letztes_byte_q;
  logic [31:0] zaehler_q;
  logic [31:0] daten_raus_q;
  logic        bereit_q;
  logic        geschrieben_q;
  logic [31:0] lese_wert;
  logic        uart_busy;
  logic        uart_start;
  logic        schreib_uart;

  assign schreib_uart = bus.SchreibenAn && (bus.Adresse == REG_UART_DATEN);
  // The CPU holds DatenRein during STALL, so the byte is taken from the bus on the load edge.
  assign uart_start   = !uart_busy && ((state_q == IDLE && schreib_uart) || state_q == STALL);

  always_comb begin
    lese_wert = '0;
    case (bus.Adresse)
      REG_LED:         lese_wert = {24'd0, led_q};
      REG_ZAEHLER:     lese_wert = zaehler_q;
      REG_UART_DATEN:  lese_wert = {24'd0, letztes_byte_q};
      REG_UART_STATUS: lese_wert = {31'd0, uart_busy};
      default:         lese_wert = '0;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) zaehler_q <= ZAEHLER_START;
    else       zaehler_q <= zaehler_q + 32'd1;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q        <= IDLE;
      led_q          <= '0;
      letztes_byte_q <= '0;
      daten_raus_q   <= '0;
      bereit_q       <= 1'b0;
      geschrieben_q  <= 1'b0;
    end else begin
      bereit_q      <= 1'b0;
      geschrieben_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.SchreibenAn) begin
            if (schreib_uart && uart_busy) begin
              state_q <= STALL;
            end else begin
              state_q       <= ACK;
              geschrieben_q <= 1'b1;
              if (bus.Adresse == REG_LED) led_q <= bus.DatenRein[7:0];
              if (schreib_uart) letztes_byte_q <= bus.DatenRein[7:0];
            end
          end else if (bus.LesenAn) begin
            state_q      <= ACK;
            bereit_q     <= 1'b1;
            daten_raus_q <= lese_wert;
          end
        end
        STALL: begin
          if (!uart_busy) begin
            state_q        <= ACK;
            geschrieben_q  <= 1'b1;
            letztes_byte_q <= bus.DatenRein[7:0];
          end
        end
        ACK: state_q <= RELEASE;
        RELEASE: begin
          if (!bus.LesenAn && !bus.SchreibenAn) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.DatenRaus        = daten_raus_q;
  assign bus.DatenBereit      = bereit_q;
  assign bus.DatenGeschrieben = geschrieben_q;
  assign Led                  = led_q;

  uart_sender #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_uart (
    .Clock (Clock),
    .Reset (Reset),
    .Start (uart_start),
    .Byte  (bus.DatenRein[7:0]),
    .Busy  (uart_busy),
    .Tx    (UartTx)
  );

endmodule
